demux_despachante: RTL and testbench

Upstream feeder for the DEMUX8x1 stage. Accepts {address, data} words on a valid/ready handshake, buffers them in a small FIFO, and presents each word on the demux inputs `dados`/`endereco` for a fixed number of cycles with a `valido` strobe. Presentation is back-to-back when the FIFO is non-empty, and the demux sees zero data when idle.

---
 rtl/despacho_pkg.sv | 11 +
 rtl/demux_despachante_if.sv | 37 +++
 rtl/despacho_fifo.sv | 75 +++++++
 rtl/demux_despachante.sv | 131 +++++++++++++
 tb/tb_demux_despachante.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/despacho_pkg.sv
// Shared types for the demux_despachante feeder: FSM state encoding and destination width.
package despacho_pkg;

    localparam int unsigned EndLargura = 3;

    typedef enum logic {
        StOcioso    = 1'b0,
        StApresenta = 1'b1
    } estado_e;

endpackage

// File: rtl/demux_despachante_if.sv
// Upstream valid/ready handshake plus the demux-facing word bus.
// master: the despachante itself; slave: the surrounding environment.
interface demux_despachante_if #(
    parameter int unsigned LARGURA = 8
);
    import despacho_pkg::*;

    logic                  in_valido;
    logic                  in_pronto;
    logic [LARGURA-1:0]    in_dados;
    logic [EndLargura-1:0] in_endereco;

    logic [LARGURA-1:0]    dados;
    logic [EndLargura-1:0] endereco;
    logic                  valido;

    modport master (
        input  in_valido,
        input  in_dados,
        input  in_endereco,
        output in_pronto,
        output dados,
        output endereco,
        output valido
    );

    modport slave (
        output in_valido,
        output in_dados,
        output in_endereco,
        input  in_pronto,
        input  dados,
        input  endereco,
        input  valido
    );

endinterface

// File: rtl/despacho_fifo.sv
// Word FIFO for the despachante: power-of-two depth, wrapping pointers, explicit full flag.
module despacho_fifo #(
    parameter int unsigned LARGURA      = 11,
    parameter int unsigned PROFUNDIDADE = 4,
    localparam int unsigned PtrW        = $clog2(PROFUNDIDADE),
    localparam int unsigned OcupW       = PtrW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [LARGURA-1:0] wdata_i,
    output logic [LARGURA-1:0] rdata_o,
    output logic               cheio_o,
    output logic               vazio_o,
    output logic [OcupW-1:0]   ocupacao_o
);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic               cheio_q, cheio_d;
    logic [OcupW-1:0]   ocup_q, ocup_d;
    logic               push_ok;
    logic               pop_ok;

    // Equal pointers mean empty unless the full flag says otherwise.
    assign vazio_o    = (wr_ptr_q == rd_ptr_q) && !cheio_q;
    assign cheio_o    = cheio_q;
    assign rdata_o    = mem_q[rd_ptr_q];
    assign ocupacao_o = ocup_q;
    assign push_ok    = push_i && !cheio_q;
    assign pop_ok     = pop_i && !vazio_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cheio_d  = cheio_q;
        ocup_d   = ocup_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            ocup_d  = ocup_q + 1'b1;
            cheio_d = (wr_ptr_d == rd_ptr_q);
        end else if (pop_ok && !push_ok) begin
            ocup_d  = ocup_q - 1'b1;
            cheio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cheio_q  <= 1'b0;
            ocup_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cheio_q  <= cheio_d;
            ocup_q   <= ocup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/demux_despachante.sv
// Feeds buffered {address, data} words to the DEMUX8x1 stage, each held for HOLD cycles.
// Optional per-destination delivery counters are built when DESPACHO_CONT_EN is defined.
module demux_despachante
    import despacho_pkg::*;
#(
    parameter int unsigned LARGURA      = 8,
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned HOLD         = 4,
    localparam int unsigned OcupW       = $clog2(PROFUNDIDADE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_despachante_if.master   bus,
    output logic [OcupW-1:0]      ocupacao,
    input  logic [EndLargura-1:0] cont_sel,
    output logic [7:0]            cont_val
);

    localparam int unsigned PalavraW          = EndLargura + LARGURA;
    localparam int unsigned HoldW             = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HoldW-1:0] HoldInit     = HoldW'(HOLD - 1);

    logic [PalavraW-1:0]   cabeca;
    logic [LARGURA-1:0]    cab_dados;
    logic [EndLargura-1:0] cab_end;
    logic                  cheio;
    logic                  vazio;
    logic                  pop;

    estado_e               estado_q;
    logic [HoldW-1:0]      hold_q;
    logic                  valido_q;
    logic [LARGURA-1:0]    dados_q;
    logic [EndLargura-1:0] end_q;

    assign {cab_end, cab_dados} = cabeca;
    assign bus.in_pronto        = !cheio && !rst;

    despacho_fifo #(
        .LARGURA      (PalavraW),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.in_valido && bus.in_pronto),
        .pop_i      (pop),
        .wdata_i    ({bus.in_endereco, bus.in_dados}),
        .rdata_o    (cabeca),
        .cheio_o    (cheio),
        .vazio_o    (vazio),
        .ocupacao_o (ocupacao)
    );

    // Pop whenever the current word has finished its hold window (or nothing is shown).
    always_comb begin
        pop = 1'b0;
        case (estado_q)
            StOcioso:    pop = !vazio;
            StApresenta: pop = !vazio && (hold_q == '0);
            default:     pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= StOcioso;
            hold_q   <= '0;
            valido_q <= 1'b0;
            dados_q  <= '0;
            end_q    <= '0;
        end else begin
            case (estado_q)
                StOcioso: begin
                    if (pop) begin
                        estado_q <= StApresenta;
                        hold_q   <= HoldInit;
                        valido_q <= 1'b1;
                        dados_q  <= cab_dados;
                        end_q    <= cab_end;
                    end
                end
                StApresenta: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else if (pop) begin
                        hold_q  <= HoldInit;
                        dados_q <= cab_dados;
                        end_q   <= cab_end;
                    end else begin
                        // Address is left as-is so the demux keeps its last selection.
                        estado_q <= StOcioso;
                        valido_q <= 1'b0;
                        dados_q  <= '0;
                    end
                end
                default: estado_q <= StOcioso;
            endcase
        end
    end

    assign bus.valido   = valido_q;
    assign bus.dados    = dados_q;
    assign bus.endereco = end_q;

`ifdef DESPACHO_CONT_EN
    logic [7:0] cont_q [8];
    logic [7:0] cont_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cont_q[i] <= '0;
            end
            cont_val_q <= '0;
        end else begin
            if (pop) begin
                cont_q[cab_end] <= cont_q[cab_end] + 8'd1;
            end
            cont_val_q <= cont_q[cont_sel];
        end
    end

    assign cont_val = cont_val_q;
`else
    logic unused_cont_sel;

    assign unused_cont_sel = ^cont_sel;
    assign cont_val        = '0;
`endif

endmodule

// File: tb/tb_demux_despachante.sv
// Bench for demux_despachante: a timestamp-based reference model scores every cycle while
// scenario tasks drive directed and random traffic (DESPACHO_CONT_EN selects counter checks).
module tb_demux_despachante;
    import despacho_pkg::*;

    localparam int unsigned L  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned OW = $clog2(D) + 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    demux_despachante_if #(.LARGURA(L)) bus ();
    demux_despachante_if #(.LARGURA(L)) bus1 ();

    logic [OW-1:0] ocup, ocup1;
    logic [2:0]    cont_sel, cont_sel1;
    logic [7:0]    cont_val, cont_val1;

    demux_despachante #(
        .LARGURA      (L),
        .PROFUNDIDADE (D),
        .HOLD         (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ocupacao (ocup),
        .cont_sel (cont_sel),
        .cont_val (cont_val)
    );

    demux_despachante #(
        .LARGURA      (L),
        .PROFUNDIDADE (D),
        .HOLD         (1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .bus      (bus1),
        .ocupacao (ocup1),
        .cont_sel (cont_sel1),
        .cont_val (cont_val1)
    );

    // Each accepted word is shown during samples [start, start+H); start is derived from
    // its accept edge and the previous word's start.
    typedef struct {
        int         start;
        logic [2:0] e;
        logic [7:0] d;
    } palavra_t;

    palavra_t mdl_q[$];
    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    function automatic int mdl_occ();
        int n = 0;
        foreach (mdl_q[i]) if (mdl_q[i].start > cyc) n++;
        return n;
    endfunction

    task automatic scoreboard();
        logic r, acc, ep, ev;
        logic [2:0] e, ee;
        logic [7:0] d, ed;
        int s, occ;
        forever begin
            @(negedge clk);
            r  = rst;
            ep = !r && (mdl_occ() < int'(D));
            checks++;
            if (bus.in_pronto !== ep) begin
                failures++;
                $display("FAIL sb_in_pronto cyc=%0d got=%b exp=%b", cyc, bus.in_pronto, ep);
            end
            acc = bus.in_valido && ep;
            e   = bus.in_endereco;
            d   = bus.in_dados;
            @(posedge clk);
            cyc++;
            if (r) begin
                mdl_q.delete();
            end else if (acc) begin
                s = cyc + 1;
                if (mdl_q.size() > 0 && mdl_q[$].start + int'(H) > s) s = mdl_q[$].start + int'(H);
                mdl_q.push_back('{s, e, d});
            end
            #1;
            ev = 1'b0;
            ee = '0;
            ed = '0;
            foreach (mdl_q[i]) begin
                if (mdl_q[i].start <= cyc) begin
                    ee = mdl_q[i].e;
                    if (cyc < mdl_q[i].start + int'(H)) begin
                        ev = 1'b1;
                        ed = mdl_q[i].d;
                    end
                end
            end
            occ = mdl_occ();
            checks++;
            if (bus.valido !== ev) begin
                failures++;
                $display("FAIL sb_valido cyc=%0d got=%b exp=%b", cyc, bus.valido, ev);
            end
            checks++;
            if (bus.dados !== ed) begin
                failures++;
                $display("FAIL sb_dados cyc=%0d got=%h exp=%h", cyc, bus.dados, ed);
            end
            checks++;
            if (bus.endereco !== ee) begin
                failures++;
                $display("FAIL sb_endereco cyc=%0d got=%0d exp=%0d", cyc, bus.endereco, ee);
            end
            checks++;
            if (ocup !== OW'(occ)) begin
                failures++;
                $display("FAIL sb_ocupacao cyc=%0d got=%0d exp=%0d", cyc, ocup, occ);
            end
        end
    endtask

    // Holds a word on the input until the DUT accepts it; leaves in_valido high.
    task automatic send(input logic [2:0] e, input logic [7:0] d);
        logic ok;
        int n;
        bus.in_endereco = e;
        bus.in_dados    = d;
        bus.in_valido   = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_pronto;
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got=stalled exp=accepted");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((ocup !== '0 || bus.valido !== 1'b0) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (ocup !== '0 || bus.valido !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout got ocup=%0d valido=%b exp=0/0", ocup, bus.valido);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.valido, bus.dados, bus.endereco, ocup} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%h_%0d_%0d exp=all zero",
                     bus.valido, bus.dados, bus.endereco, ocup);
        end
        checks++;
        if (bus.in_pronto !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_pronto got=%b exp=0", bus.in_pronto);
        end
        checks++;
        if (cont_val !== 8'd0) begin
            failures++;
            $display("FAIL reset_cont_val got=%0d exp=0", cont_val);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.in_pronto !== 1'b1) begin
            failures++;
            $display("FAIL release_in_pronto got=%b exp=1", bus.in_pronto);
        end
    endtask

    task automatic test_single();
        send(3'd3, 8'h08);
        bus.in_valido = 1'b0;
        checks++;
        if (bus.valido !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got=%b exp=0", bus.valido);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.valido, bus.endereco, bus.dados} !== {1'b1, 3'd3, 8'h08}) begin
                failures++;
                $display("FAIL single_hold[%0d] got=%b/%0d/%h exp=1/3/08",
                         i, bus.valido, bus.endereco, bus.dados);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valido, bus.endereco, bus.dados} !== {1'b0, 3'd3, 8'h00}) begin
            failures++;
            $display("FAIL single_idle got=%b/%0d/%h exp=0/3/00",
                     bus.valido, bus.endereco, bus.dados);
        end
    endtask

    task automatic test_back_to_back();
        int run, waitn, bad, max_occ;
        logic saw_stall;
        run = 0; bad = 0; max_occ = 0; saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(3'(i), 8'(1 << i));
                bus.in_valido = 1'b0;
            end
            begin
                waitn = 0;
                while (bus.valido !== 1'b1 && waitn < 20) begin
                    @(posedge clk);
                    #1;
                    waitn++;
                end
                while (bus.valido === 1'b1 && run < 100) begin
                    if ({bus.endereco, bus.dados} !== {3'(run / 4), 8'(1 << (run / 4))}) bad++;
                    run++;
                    @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (bus.in_valido && !bus.in_pronto) saw_stall = 1'b1;
                    if (int'(ocup) > max_occ) max_occ = int'(ocup);
                end
            end
        join
        checks++;
        if (run != 32) begin
            failures++;
            $display("FAIL b2b_valid_run got=%0d exp=32", run);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_order got=%0d wrong cycles exp=0", bad);
        end
        checks++;
        if (!saw_stall || max_occ != 4) begin
            failures++;
            $display("FAIL b2b_backpressure got stall=%b max_occ=%0d exp=1/4", saw_stall, max_occ);
        end
    endtask

    task automatic test_full_stall();
        int stalls, n, bad;
        logic acc;
        for (int i = 0; i < 5; i++) send(3'($urandom), 8'($urandom));
        bus.in_endereco = 3'($urandom);
        bus.in_dados    = 8'($urandom);
        stalls = 0; n = 0; bad = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (bus.in_pronto) begin
                acc = 1'b1;
                checks++;
                if (ocup !== OW'(3)) begin
                    failures++;
                    $display("FAIL stall_resume_ocup got=%0d exp=3", ocup);
                end
            end else begin
                stalls++;
                if (ocup !== OW'(4)) bad++;
            end
            @(posedge clk);
            #2;
            n++;
        end
        bus.in_valido = 1'b0;
        checks++;
        if (!acc || stalls == 0 || bad != 0) begin
            failures++;
            $display("FAIL stall_window got acc=%b stalls=%0d not_full=%0d exp=1/>0/0",
                     acc, stalls, bad);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        for (int i = 0; i < 4; i++) send(3'($urandom), 8'($urandom_range(1, 255)));
        bus.in_valido = 1'b0;
        checks++;
        if (ocup !== OW'(3) || bus.valido !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup got ocup=%0d valido=%b exp=3/1", ocup, bus.valido);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valido, bus.dados, bus.endereco, ocup} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b_%h_%0d_%0d exp=all zero",
                     bus.valido, bus.dados, bus.endereco, ocup);
        end
        #1 rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.valido !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrst_dropped got=%0d valid cycles exp=0", seen);
        end
    endtask

    task automatic test_random();
        int vcnt, n, gap;
        logic done;
        vcnt = 0; n = 0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    gap = int'($urandom_range(0, 6));
                    if (gap > 0) begin
                        bus.in_valido = 1'b0;
                        repeat (gap) begin
                            @(posedge clk);
                            #2;
                        end
                    end
                    send(3'($urandom), 8'($urandom));
                end
                bus.in_valido = 1'b0;
                done = 1'b1;
            end
            begin
                while (!(done && ocup === '0 && bus.valido === 1'b0) && n < 3000) begin
                    @(posedge clk);
                    #1;
                    if (bus.valido === 1'b1) vcnt++;
                    n++;
                end
            end
        join
        checks++;
        if (vcnt != 40 * int'(H)) begin
            failures++;
            $display("FAIL random_valid_cycles got=%0d exp=%0d", vcnt, 40 * H);
        end
    endtask

    task automatic test_hold1();
        logic [10:0] w [10];
        int stall, bad, n;
        stall = 0; bad = 0; n = 0;
        for (int i = 0; i < 10; i++) w[i] = 11'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.valido, bus1.dados, ocup1, cont_val1} !== '0) begin
            failures++;
            $display("FAIL hold1_reset got=%b_%h_%0d_%0d exp=all zero",
                     bus1.valido, bus1.dados, ocup1, cont_val1);
        end
        #1 rst1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bus1.in_endereco = w[i][10:8];
                    bus1.in_dados    = w[i][7:0];
                    bus1.in_valido   = 1'b1;
                    @(negedge clk);
                    if (!bus1.in_pronto) stall++;
                    @(posedge clk);
                    #2;
                end
                bus1.in_valido = 1'b0;
            end
            begin
                while (bus1.valido !== 1'b1 && n < 5) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    if ({bus1.valido, bus1.endereco, bus1.dados} !== {1'b1, w[i]}) bad++;
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (bus1.valido !== 1'b0 || ocup1 !== '0) begin
                    failures++;
                    $display("FAIL hold1_end got valido=%b ocup=%0d exp=0/0", bus1.valido, ocup1);
                end
            end
        join
        checks++;
        if (stall != 0 || bad != 0) begin
            failures++;
            $display("FAIL hold1_stream got stalls=%0d wrong=%0d exp=0/0", stall, bad);
        end
    endtask

    task automatic test_counters();
`ifdef DESPACHO_CONT_EN
        logic [7:0] exp_cnt;
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 300; i++) send(3'd5, 8'($urandom));
        for (int i = 0; i < 2; i++) send(3'd0, 8'($urandom));
        bus.in_valido = 1'b0;
        drain();
        for (int s = 0; s < 8; s++) begin
            cont_sel = 3'(s);
            exp_cnt  = (s == 5) ? 8'd44 : ((s == 0) ? 8'd2 : 8'd0);
            @(posedge clk);
            #1;
            checks++;
            if (cont_val !== exp_cnt) begin
                failures++;
                $display("FAIL cont_val[%0d] got=%0d exp=%0d", s, cont_val, exp_cnt);
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            cont_sel = 3'($urandom);
            send(cont_sel, 8'($urandom));
            bus.in_valido = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (cont_val !== 8'd0) begin
                failures++;
                $display("FAIL cont_val_disabled sel=%0d got=%0d exp=0", cont_sel, cont_val);
            end
        end
        drain();
`endif
    endtask

    initial begin
        bus.in_valido    = 1'b0;
        bus.in_dados     = '0;
        bus.in_endereco  = '0;
        bus1.in_valido   = 1'b0;
        bus1.in_dados    = '0;
        bus1.in_endereco = '0;
        cont_sel         = '0;
        cont_sel1        = '0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_reset_mid();
        test_random();
        test_hold1();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
